// File: rtl/jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_sequencer
// Function : Command-driven J/K driver for a bank of W JK flip-flops with a
//            shadow model and post-sequence check of the bank's Q outputs.
// Revision : 1.0
// ============================================================================
module jk_bank_sequencer #(
  parameter int W  = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [W-1:0]  cmd_mask,
  input  logic [W-1:0]  cmd_data,
  input  logic [CW-1:0] cmd_count,
  output logic [W-1:0]  j_out,
  output logic [W-1:0]  k_out,
  input  logic [W-1:0]  q_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  err_bits
);

  localparam logic [2:0]    c_OP_NOP    = 3'd0;
  localparam logic [2:0]    c_OP_SET    = 3'd1;
  localparam logic [2:0]    c_OP_CLEAR  = 3'd2;
  localparam logic [2:0]    c_OP_TOGGLE = 3'd3;
  localparam logic [2:0]    c_OP_LOAD   = 3'd4;
  localparam logic [2:0]    c_OP_COUNT  = 3'd5;
  localparam logic [W-1:0]  c_W_ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] c_CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_op;
  logic [W-1:0]  r_mask;
  logic [W-1:0]  r_data;
  logic [W-1:0]  r_shadow;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [W-1:0]  r_err_bits;
  logic [W-1:0]  w_shadow_nxt;
  logic [W-1:0]  w_toggle;
  logic [W-1:0]  w_eff_mask;
  logic [W-1:0]  w_diff;
  logic          w_accept;
  logic          w_op_reserved;

  // Bits that flip on a binary increment of the shadow.
  assign w_toggle      = r_shadow ^ (r_shadow + c_W_ONE);
  assign w_eff_mask    = (r_op == c_OP_COUNT) ? {W{1'b1}} : r_mask;
  assign w_diff        = (q_in ^ r_shadow) & w_eff_mask;
  assign w_op_reserved = (cmd_op > c_OP_COUNT);

  // Gating with reset keeps ready low while the controller is held in reset.
  assign cmd_ready = (r_state == S_IDLE) && reset;
  assign w_accept  = cmd_ready && cmd_valid;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign err_bits  = r_err_bits;

  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    j_out        = '0;
    k_out        = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((cmd_op == c_OP_NOP) || w_op_reserved) w_state_nxt = S_DONE;
          else                                        w_state_nxt = S_APPLY;
        end
      end
      S_APPLY: begin
        case (r_op)
          c_OP_SET: begin
            j_out        = r_mask;
            w_shadow_nxt = r_shadow | r_mask;
          end
          c_OP_CLEAR: begin
            k_out        = r_mask;
            w_shadow_nxt = r_shadow & ~r_mask;
          end
          c_OP_TOGGLE: begin
            j_out        = r_mask;
            k_out        = r_mask;
            w_shadow_nxt = r_shadow ^ r_mask;
          end
          c_OP_LOAD: begin
            j_out        = r_mask & r_data;
            k_out        = r_mask & ~r_data;
            w_shadow_nxt = (r_shadow & ~r_mask) | (r_data & r_mask);
          end
          c_OP_COUNT: begin
            j_out        = w_toggle;
            k_out        = w_toggle;
            w_shadow_nxt = r_shadow + c_W_ONE;
          end
          default: ;
        endcase
        if (r_cnt == '0) w_state_nxt = S_CHECK;
      end
      S_CHECK: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_mask     <= '0;
      r_data     <= '0;
      r_shadow   <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_err_bits <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op       <= cmd_op;
        r_mask     <= cmd_mask;
        r_data     <= cmd_data;
        r_cnt      <= cmd_count;
        r_shadow   <= q_in;
        r_err      <= w_op_reserved;
        r_err_bits <= '0;
      end else if (r_state == S_APPLY) begin
        r_shadow <= w_shadow_nxt;
        r_cnt    <= r_cnt - c_CNT_ONE;
      end else if (r_state == S_CHECK) begin
        r_err_bits <= w_diff;
        r_err      <= |w_diff;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_sequencer
// Function : Directed bench driving jk_bank_sequencer against a JK bank model.
// Revision : 1.0
// ============================================================================
module tb_jk_bank_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [3:0] cmd_data;
  logic [3:0] cmd_count;
  logic [3:0] j_out;
  logic [3:0] k_out;
  logic [3:0] q_in;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] err_bits;

  logic [3:0] bank_q;
  logic [3:0] bank_val;
  logic       bank_ld;
  logic [3:0] stuck0;

  int n_cmp;
  int n_err;

  jk_bank_sequencer #(.W(4), .CW(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .j_out(j_out), .k_out(k_out), .q_in(q_in), .busy(busy), .done(done),
    .err(err), .err_bits(err_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK bank: q+ = J&~q | ~K&q, with an optional stuck-at-0 on the read path.
  always @(posedge clk) begin
    if (bank_ld) bank_q <= bank_val;
    else         bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
  end
  assign q_in = bank_q & ~stuck0;

  task automatic set_bank(input logic [3:0] v);
    @(negedge clk);
    bank_val = v;
    bank_ld  = 1'b1;
    @(negedge clk);
    bank_ld  = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] m, input logic [3:0] d,
                       input logic [3:0] c);
    @(negedge clk);
    cmd_op = op; cmd_mask = m; cmd_data = d; cmd_count = c; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd1; cmd_mask = 4'hF;
    set_bank(4'b0000);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
    n_cmp++; if (j_out !== 4'b0 || k_out !== 4'b0) begin n_err++; $display("FAIL rst_jk: got j=%b k=%b want 0000", j_out, k_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL rst_done_err: got done=%b err=%b want 0", done, err); end
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_set;
    set_bank(4'b0000);
    issue(3'd1, 4'b1010, 4'b0000, 4'd0);
    @(negedge clk);
    n_cmp++; if (j_out !== 4'b1010 || k_out !== 4'b0000) begin n_err++; $display("FAIL set_jk: got j=%b k=%b want 1010/0000", j_out, k_out); end
    n_cmp++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL set_busy: got busy=%b ready=%b want 1/0", busy, cmd_ready); end
    @(negedge clk);
    n_cmp++; if (j_out !== 4'b0 || k_out !== 4'b0 || done !== 1'b0) begin n_err++; $display("FAIL set_chk: got j=%b k=%b done=%b want 0", j_out, k_out, done); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL set_done: got done=%b err=%b want 1/0", done, err); end
    n_cmp++; if (q_in !== 4'b1010) begin n_err++; $display("FAIL set_q: got %b want 1010", q_in); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL set_idle: got done=%b ready=%b want 0/1", done, cmd_ready); end
  endtask

  task automatic test_load;
    set_bank(4'b1010);
    issue(3'd4, 4'b1100, 4'b0101, 4'd2);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++; if (j_out !== 4'b0100 || k_out !== 4'b1000) begin n_err++; $display("FAIL load_jk c%0d: got j=%b k=%b want 0100/1000", c, j_out, k_out); end
    end
    @(negedge clk);
    n_cmp++; if (j_out !== 4'b0 || done !== 1'b0) begin n_err++; $display("FAIL load_chk: got j=%b done=%b want 0000/0", j_out, done); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || err !== 1'b0 || q_in !== 4'b0110) begin n_err++; $display("FAIL load_done: got done=%b err=%b q=%b want 1/0/0110", done, err, q_in); end
  endtask

  task automatic test_count;
    logic [3:0] ejk [5];
    logic [3:0] eq  [5];
    ejk = '{4'b0011, 4'b0001, 4'b1111, 4'b0001, 4'b0011};
    eq  = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};
    set_bank(4'b1101);
    issue(3'd5, 4'b0000, 4'b0000, 4'd4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (j_out !== ejk[c] || k_out !== ejk[c]) begin n_err++; $display("FAIL cnt_jk c%0d: got j=%b k=%b want %b", c + 1, j_out, k_out, ejk[c]); end
      if (c > 0) begin
        n_cmp++; if (q_in !== eq[c-1]) begin n_err++; $display("FAIL cnt_q c%0d: got %b want %b", c + 1, q_in, eq[c-1]); end
      end
    end
    @(negedge clk);
    n_cmp++; if (q_in !== eq[4] || j_out !== 4'b0) begin n_err++; $display("FAIL cnt_chk: got q=%b j=%b want %b/0000", q_in, j_out, eq[4]); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL cnt_done: got done=%b err=%b want 1/0", done, err); end
  endtask

  task automatic test_stuck;
    set_bank(4'b0000);
    stuck0 = 4'b0100;
    issue(3'd3, 4'b0100, 4'b0000, 4'd0);
    @(negedge clk);
    n_cmp++; if (j_out !== 4'b0100 || k_out !== 4'b0100) begin n_err++; $display("FAIL tog_jk: got j=%b k=%b want 0100", j_out, k_out); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || err !== 1'b1 || err_bits !== 4'b0100) begin n_err++; $display("FAIL stuck_err: got done=%b err=%b bits=%b want 1/1/0100", done, err, err_bits); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b1 || err_bits !== 4'b0100) begin n_err++; $display("FAIL stuck_hold: got err=%b bits=%b want 1/0100", err, err_bits); end
    stuck0 = 4'b0000;
  endtask

  task automatic test_nop_reserved;
    issue(3'd0, 4'b1111, 4'b0000, 4'd3);
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || err !== 1'b0 || err_bits !== 4'b0) begin n_err++; $display("FAIL nop_done: got done=%b err=%b bits=%b want 1/0/0000", done, err, err_bits); end
    issue(3'd7, 4'b1111, 4'b1111, 4'd3);
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || err !== 1'b1 || err_bits !== 4'b0) begin n_err++; $display("FAIL rsv_done: got done=%b err=%b bits=%b want 1/1/0000", done, err, err_bits); end
    n_cmp++; if (j_out !== 4'b0 || k_out !== 4'b0) begin n_err++; $display("FAIL rsv_jk: got j=%b k=%b want 0000", j_out, k_out); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b1 || j_out !== 4'b0) begin n_err++; $display("FAIL rsv_after: got done=%b ready=%b err=%b j=%b want 0/1/1/0000", done, cmd_ready, err, j_out); end
  endtask

  task automatic test_reset_mid;
    logic seen_done;
    set_bank(4'b0000);
    issue(3'd3, 4'b1111, 4'b0000, 4'd5);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (j_out !== 4'b1111) begin n_err++; $display("FAIL mid_pre: got j=%b want 1111", j_out); end
    reset = 1'b0;
    #1;
    n_cmp++; if (j_out !== 4'b0 || k_out !== 4'b0) begin n_err++; $display("FAIL mid_jk: got j=%b k=%b want 0000", j_out, k_out); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mid_busy: got busy=%b done=%b want 0/0", busy, done); end
    @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    n_cmp++; if (seen_done !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_nodone: got done_seen=%b ready=%b want 0/1", seen_done, cmd_ready); end
  endtask

  task automatic test_back_to_back;
    logic got_done;
    set_bank(4'b0000);
    issue(3'd1, 4'b0001, 4'b0000, 4'd1);
    cmd_op = 3'd2; cmd_mask = 4'b0011; cmd_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_cmp++; if (cmd_ready !== 1'b0 || k_out !== 4'b0) begin n_err++; $display("FAIL b2b_busy c%0d: got ready=%b k=%b want 0/0000", c, cmd_ready, k_out); end
      n_cmp++; if (j_out !== ((c <= 2) ? 4'b0001 : 4'b0000) || done !== (c == 4)) begin n_err++; $display("FAIL b2b_seq c%0d: got j=%b done=%b", c, j_out, done); end
    end
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++; if (k_out !== 4'b0011 || j_out !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_clr: got j=%b k=%b busy=%b want 0000/0011/1", j_out, k_out, busy); end
    got_done = 1'b0;
    for (int c = 0; c < 12 && !got_done; c++) begin
      @(negedge clk);
      if (done === 1'b1) got_done = 1'b1;
    end
    n_cmp++; if (got_done !== 1'b1) begin n_err++; $display("FAIL b2b_timeout: got done=%b want 1", got_done); end
    n_cmp++; if (q_in !== 4'b0000 || err !== 1'b0) begin n_err++; $display("FAIL b2b_final: got q=%b err=%b want 0000/0", q_in, err); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; cmd_data = '0; cmd_count = '0;
    bank_ld = 1'b0; bank_val = '0; stuck0 = '0; reset = 1'b0;
    test_reset();
    test_set();
    test_load();
    test_count();
    test_stuck();
    test_nop_reserved();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
